// File: rtl/demux_2_bit_reg_pkg.sv
// Shared base-module definitions for the slot demultiplexer: FSM encodings,
// the full-mask constant and a slot-to-mask-bit helper.
package demux_2_bit_reg_pkg;

  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] PARTIAL = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam logic [3:0] MASK_FULL = 4'b1111;

  function automatic logic [3:0] slot_bit(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/demux_2_bit_reg_slot.sv
// One output slot: a DATA_WIDTH register with load enable and asynchronous
// active-low reset. Data is only ever cleared by reset.
module demux_slot_reg #(
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/demux_2_bit_reg.sv
// Registered 1-to-4 demultiplexer: scatters slot-addressed writes into a
// 4-slot word, tracks filled slots and pulses on completion or overwrite.
module demux_2_bit_reg
  import demux_2_bit_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    write_enable,
  input  logic [1:0]              selector,
  input  logic [DATA_WIDTH-1:0]   data_input,
  input  logic                    clear,
  output logic [4*DATA_WIDTH-1:0] data_output,
  output logic [3:0]              written_mask,
  output logic                    word_valid,
  output logic                    overwrite_error
);

  logic [1:0] state;
  logic [1:0] state_next;
  logic [3:0] mask_next;
  logic       word_valid_next;
  logic       overwrite_next;
  logic       write_accept;
  logic [3:0] sel_bit;
  logic [3:0] mask_merged;

  assign write_accept = write_enable & ~clear;
  assign sel_bit      = slot_bit(selector);
  assign mask_merged  = written_mask | sel_bit;

  for (genvar n = 0; n < 4; n++) begin : g_slot
    demux_slot_reg #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk    (clk),
      .reset_n(reset_n),
      .load   (write_accept & (selector == 2'(n))),
      .d      (data_input),
      .q      (data_output[n*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Clear wins over any write; DONE lasts one cycle and a write there opens a new word.
  always_comb begin
    state_next      = state;
    mask_next       = written_mask;
    word_valid_next = 1'b0;
    overwrite_next  = 1'b0;
    if (clear) begin
      state_next = EMPTY;
      mask_next  = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (write_enable) begin
            mask_next  = sel_bit;
            state_next = PARTIAL;
          end
        end
        PARTIAL: begin
          if (write_enable) begin
            if ((written_mask & sel_bit) != '0) begin
              overwrite_next = 1'b1;
            end else if (mask_merged == MASK_FULL) begin
              mask_next       = '0;
              word_valid_next = 1'b1;
              state_next      = DONE;
            end else begin
              mask_next = mask_merged;
            end
          end
        end
        DONE: begin
          if (write_enable) begin
            mask_next  = sel_bit;
            state_next = PARTIAL;
          end else begin
            mask_next  = '0;
            state_next = EMPTY;
          end
        end
        default: begin
          mask_next  = '0;
          state_next = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= EMPTY;
      written_mask    <= '0;
      word_valid      <= 1'b0;
      overwrite_error <= 1'b0;
    end else begin
      state           <= state_next;
      written_mask    <= mask_next;
      word_valid      <= word_valid_next;
      overwrite_error <= overwrite_next;
    end
  end

endmodule

// File: tb/tb_demux_2_bit_reg.sv
// Scoreboard bench for demux_2_bit_reg: directed vectors drive an 8-bit and a
// 1-bit instance in parallel; a monitor pops expected outputs each cycle.
module tb_demux_2_bit_reg;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        write_enable = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  selector = '0;
  logic [7:0]  din = '0;

  logic [31:0] dout8;
  logic [3:0]  mask8;
  logic        wv8, oe8;
  logic [3:0]  dout1;
  logic [3:0]  mask1;
  logic        wv1, oe1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    int          idx;
    logic [3:0]  mask;
    logic        wv;
    logic        oe;
    logic [31:0] data;
  } exp_t;

  exp_t expq[$];

  always #5 clk = ~clk;

  demux_2_bit_reg #(.DATA_WIDTH(8)) dut8 (
    .clk            (clk),
    .reset_n        (reset_n),
    .write_enable   (write_enable),
    .selector       (selector),
    .data_input     (din),
    .clear          (clear),
    .data_output    (dout8),
    .written_mask   (mask8),
    .word_valid     (wv8),
    .overwrite_error(oe8)
  );

  demux_2_bit_reg #(.DATA_WIDTH(1)) dut1 (
    .clk            (clk),
    .reset_n        (reset_n),
    .write_enable   (write_enable),
    .selector       (selector),
    .data_input     (din[0]),
    .clear          (clear),
    .data_output    (dout1),
    .written_mask   (mask1),
    .word_valid     (wv1),
    .overwrite_error(oe1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    logic [3:0] exp_w1;
    #1;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      exp_w1 = {e.data[24], e.data[16], e.data[8], e.data[0]};
      check($sformatf("v%0d mask8", e.idx), 32'(mask8), 32'(e.mask));
      check($sformatf("v%0d word_valid8", e.idx), 32'(wv8), 32'(e.wv));
      check($sformatf("v%0d overwrite8", e.idx), 32'(oe8), 32'(e.oe));
      check($sformatf("v%0d data8", e.idx), dout8, e.data);
      check($sformatf("v%0d mask1", e.idx), 32'(mask1), 32'(e.mask));
      check($sformatf("v%0d word_valid1", e.idx), 32'(wv1), 32'(e.wv));
      check($sformatf("v%0d overwrite1", e.idx), 32'(oe1), 32'(e.oe));
      check($sformatf("v%0d data1", e.idx), 32'(dout1), 32'(exp_w1));
    end
  end

  // Drives one vector at the current negedge, queues its post-edge expectation,
  // and returns at the following negedge.
  task automatic apply(input int idx, input logic clr, input logic we, input logic [1:0] sel,
                       input logic [7:0] d, input logic [3:0] m, input logic wv,
                       input logic oe, input logic [31:0] data);
    exp_t e;
    clear        = clr;
    write_enable = we;
    selector     = sel;
    din          = d;
    e.idx  = idx;
    e.mask = m;
    e.wv   = wv;
    e.oe   = oe;
    e.data = data;
    expq.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clear        = 1'b0;
    write_enable = 1'b0;
    selector     = '0;
    din          = '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " data8"}, dout8, 32'h0);
    check({tag, " data1"}, 32'(dout1), 32'h0);
    check({tag, " mask8"}, 32'(mask8), 32'h0);
    check({tag, " mask1"}, 32'(mask1), 32'h0);
    check({tag, " wv8"}, 32'(wv8), 32'h0);
    check({tag, " oe8"}, 32'(oe8), 32'h0);
    check({tag, " state8"}, 32'(dut8.state), 32'h0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 10 && expq.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL %s drain: got %0d pending expected 0", tag, expq.size());
      expq.delete();
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset("power_on_reset");
    reset_n = 1'b1;

    // In-order fill: lsbs 1,0,1,1 -> 1-bit word 4'b1101
    apply(1,  0, 1, 2'd0, 8'h11, 4'b0001, 0, 0, 32'h0000_0011);
    apply(2,  0, 1, 2'd1, 8'h20, 4'b0011, 0, 0, 32'h0000_2011);
    apply(3,  0, 1, 2'd2, 8'h33, 4'b0111, 0, 0, 32'h0033_2011);
    apply(4,  0, 1, 2'd3, 8'h45, 4'b0000, 1, 0, 32'h4533_2011);
    apply(5,  0, 0, 2'd0, 8'h00, 4'b0000, 0, 0, 32'h4533_2011);
    // Out-of-order fill 3,1,0,2 then a write in the DONE cycle
    apply(6,  0, 1, 2'd3, 8'h02, 4'b1000, 0, 0, 32'h0233_2011);
    apply(7,  0, 1, 2'd1, 8'h07, 4'b1010, 0, 0, 32'h0233_0711);
    apply(8,  0, 1, 2'd0, 8'h80, 4'b1011, 0, 0, 32'h0233_0780);
    apply(9,  0, 1, 2'd2, 8'hC3, 4'b0000, 1, 0, 32'h02C3_0780);
    apply(10, 0, 1, 2'd2, 8'h5A, 4'b0100, 0, 0, 32'h025A_0780);
    // Clear, then duplicate write to slot 1
    apply(11, 1, 0, 2'd0, 8'h00, 4'b0000, 0, 0, 32'h025A_0780);
    apply(12, 0, 1, 2'd1, 8'h10, 4'b0010, 0, 0, 32'h025A_1080);
    apply(13, 0, 1, 2'd1, 8'h21, 4'b0010, 0, 1, 32'h025A_2180);
    apply(14, 0, 0, 2'd0, 8'h00, 4'b0010, 0, 0, 32'h025A_2180);
    // Reach mask 0111, then clear colliding with a write to slot 3
    apply(15, 0, 1, 2'd0, 8'h66, 4'b0011, 0, 0, 32'h025A_2166);
    apply(16, 0, 1, 2'd2, 8'h99, 4'b0111, 0, 0, 32'h0299_2166);
    apply(17, 1, 1, 2'd3, 8'hFF, 4'b0000, 0, 0, 32'h0299_2166);
    apply(18, 0, 0, 2'd0, 8'h00, 4'b0000, 0, 0, 32'h0299_2166);
    // Wide slot write leaves other bytes intact
    apply(19, 0, 1, 2'd2, 8'hA5, 4'b0100, 0, 0, 32'h02A5_2166);
    apply(20, 0, 1, 2'd0, 8'h01, 4'b0101, 0, 0, 32'h02A5_2101);
    idle_inputs();
    drain("main");

    // Asynchronous reset in the middle of a partial word
    reset_n = 1'b0;
    #1;
    check_reset("mid_cycle_reset");
    @(negedge clk);
    reset_n = 1'b1;
    apply(21, 0, 1, 2'd3, 8'h01, 4'b1000, 0, 0, 32'h0100_0000);
    apply(22, 0, 0, 2'd0, 8'h00, 4'b1000, 0, 0, 32'h0100_0000);
    idle_inputs();
    drain("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
